alu_logic_arbiter: RTL and testbench
====================================

// Module: alu_logic_arbiter
// PURPOSE
//  Shares one registered ALU logic unit (AND/OR/XOR, RV32 sign-extend) between two requesters
//  (req0 = integer execute path, req1 = auxiliary path, e.g. debug/CSR bit ops).
//  Round-robin arbitration, one operation in flight, valid/ready on both request and response sides.
//  Sits in the execute stage beside the logic unit; the parent instantiates the shared unit.
// PARAMETERS
//  (none)  data width is RISCV_ARCH (64), taken from river_cfg_pkg
// PORTS
//  i_clk           in   1        clock
//  i_nrst          in   1        reset, synchronous, active-low
//  i_req0_valid    in   1        requester 0 has an operation
//  o_req0_ready    out  1        requester 0 operation accepted this cycle when valid&ready
//  i_req0_op       in   3        one-hot {XOR,OR,AND}, forwarded unchanged
//  i_req0_rv32     in   1        32-bit mode: unit sign-extends result bit 31
//  i_req0_a1/a2    in   64 each  operands
//  o_resp0_valid   out  1        result for requester 0 available
//  i_resp0_ready   in   1        requester 0 consumes the result
//  o_resp0_data    out  64       result
//  i_req1_* / o_req1_ready / o_resp1_* / i_resp1_ready   same as req0, for requester 1
//  o_alu_op        out  3        to shared unit
//  o_alu_rv32      out  1        to shared unit
//  o_alu_a1/a2     out  64 each  to shared unit
//  i_alu_res       in   64       shared unit registered output (value of inputs one cycle earlier)
// BEHAVIOUR
//  Registers: state, owner (0/1), last_grant, op, rv32, a1, a2. Reset: state=IDLE, last_grant=1,
//   others 0. All outputs 0 while in reset; sync reset mid-operation drops in-flight op and result.
//  o_alu_* always driven from held registers (op/rv32/a1/a2).
//  States:
//   IDLE: grant = sole valid requester; both valid -> requester != last_grant.
//    ready asserted to granted requester only (combinational). On accept: latch op/operands,
//    owner=grant, last_grant=grant, -> EXEC. No valid -> stay.
//   EXEC: unit samples held inputs; no ready, no resp valid. -> RESP unconditionally.
//   RESP: o_resp<owner>_valid=1, o_resp<owner>_data=i_alu_res (stable: inputs held). Other resp
//    valid=0, data=0.
//    i_resp<owner>_ready=0 -> stay (hold indefinitely).
//    i_resp<owner>_ready=1 -> result consumed; same cycle arbitration as in IDLE (ready may be
//     granted, combinationally dependent on i_resp<owner>_ready); accept -> EXEC, else -> IDLE.
//  Latency: accept in cycle N -> resp valid in N+2; max throughput one op per 2 cycles.
//  Fairness: with both requesters continuously valid, grants alternate 0,1,0,1...
//  Request valid dropped without handshake: no effect (nothing latched). Operands sampled only at
//   accept; later changes on i_req* ignored.
//  Invalid op encodings (0 or multi-hot) forwarded unchanged; result is whatever the unit yields.
//  o_alu_* equal 0 after reset until first accept.
// STRUCTURE
//  alu_logic_arbiter_pkg: state enum {IDLE, EXEC, RESP}, AluLogicArbiter_registers struct
//   (state, owner, last_grant, op, rv32, a1, a2), AluLogicArbiter_r_reset constant.
//  Imports river_cfg_pkg (RISCV_ARCH). No sub-module; grant logic is inline (2 requesters).
// TESTING
//  1 Reset: hold i_nrst=0 with both valid -> all ready/valid 0, o_alu_*=0; release -> req0 granted first.
//  2 Single op: req0 AND a1=0xF0F0..F0F0, a2=0xFF00..FF00 accepted N -> resp0_valid at N+2,
//    data 0xF000..F000; resp1_valid stays 0.
//  3 RV32: req1 OR a1=0x0000_0000_8000_0000, a2=0x1, rv32=1 -> resp1_data 0xFFFF_FFFF_8000_0001.
//  4 Contention: both valid for 8 ops, ready always 1 -> grants 0,1,0,1..., new accept each RESP
//    cycle, 4 results each, no gaps beyond 1 EXEC cycle per op.
//  5 Backpressure: resp0_ready=0 for 5 cycles -> data stable, no req accepted; ready=1 -> req1 accepted same cycle.
//  6 Reset in EXEC and in RESP -> next cycle IDLE, all resp valid 0, pending result never delivered.

Source files
------------

// File: rtl/alu_logic_arbiter_pkg.sv
// Types and reset constant for the shared logic-unit arbiter.
package alu_logic_arbiter_pkg;
  import river_cfg_pkg::*;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } alu_logic_arbiter_state_e;

  // Everything the arbiter remembers between cycles; the held op/operands
  // feed the shared unit directly so its registered result stays stable.
  typedef struct packed {
    alu_logic_arbiter_state_e state;
    logic                     owner;
    logic                     last_grant;
    logic [2:0]               op;
    logic                     rv32;
    logic [RISCV_ARCH-1:0]    a1;
    logic [RISCV_ARCH-1:0]    a2;
  } AluLogicArbiter_registers;

  // last_grant starts at 1 so requester 0 wins the first contended round.
  localparam AluLogicArbiter_registers AluLogicArbiter_r_reset = '{
    state:      IDLE,
    owner:      1'b0,
    last_grant: 1'b1,
    op:         3'b000,
    rv32:       1'b0,
    a1:         '0,
    a2:         '0
  };

endpackage

// File: rtl/river_cfg_pkg.sv
// Core configuration constants shared across the execute stage.
package river_cfg_pkg;

  // Native integer register width of the core.
  localparam int RISCV_ARCH = 64;

endpackage

// File: rtl/alu_logic_arbiter.sv
// Round-robin arbiter sharing one registered logic unit between two
// requesters, one operation in flight, valid/ready on both sides.
module alu_logic_arbiter
  import river_cfg_pkg::*;
  import alu_logic_arbiter_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic                  i_req0_valid,
  output logic                  o_req0_ready,
  input  logic [2:0]            i_req0_op,
  input  logic                  i_req0_rv32,
  input  logic [RISCV_ARCH-1:0] i_req0_a1,
  input  logic [RISCV_ARCH-1:0] i_req0_a2,
  output logic                  o_resp0_valid,
  input  logic                  i_resp0_ready,
  output logic [RISCV_ARCH-1:0] o_resp0_data,
  input  logic                  i_req1_valid,
  output logic                  o_req1_ready,
  input  logic [2:0]            i_req1_op,
  input  logic                  i_req1_rv32,
  input  logic [RISCV_ARCH-1:0] i_req1_a1,
  input  logic [RISCV_ARCH-1:0] i_req1_a2,
  output logic                  o_resp1_valid,
  input  logic                  i_resp1_ready,
  output logic [RISCV_ARCH-1:0] o_resp1_data,
  output logic [2:0]            o_alu_op,
  output logic                  o_alu_rv32,
  output logic [RISCV_ARCH-1:0] o_alu_a1,
  output logic [RISCV_ARCH-1:0] o_alu_a2,
  input  logic [RISCV_ARCH-1:0] i_alu_res
);

  AluLogicArbiter_registers r_q;
  AluLogicArbiter_registers r_d;

  logic grant;
  logic arb_en;
  logic accept;
  logic owner_ready;

  // Grant selection, handshake decode and next-state computation.
  always_comb begin
    r_d         = r_q;
    owner_ready = r_q.owner ? i_resp1_ready : i_resp0_ready;
    // With both valid the requester that did not win last time goes next;
    // otherwise the sole valid requester (value irrelevant if none).
    if (i_req0_valid && i_req1_valid) begin
      grant = ~r_q.last_grant;
    end else begin
      grant = ~i_req0_valid;
    end
    // A new op may be taken when idle, or in the same cycle the current
    // result is consumed, which gives back-to-back ops every 2 cycles.
    arb_en = (r_q.state == IDLE) || ((r_q.state == RESP) && owner_ready);
    accept = arb_en && (i_req0_valid || i_req1_valid);

    case (r_q.state)
      IDLE:    r_d.state = IDLE;
      EXEC:    r_d.state = RESP;
      RESP:    r_d.state = owner_ready ? IDLE : RESP;
      default: r_d.state = IDLE;
    endcase

    if (accept) begin
      r_d.state      = EXEC;
      r_d.owner      = grant;
      r_d.last_grant = grant;
      r_d.op         = grant ? i_req1_op   : i_req0_op;
      r_d.rv32       = grant ? i_req1_rv32 : i_req0_rv32;
      r_d.a1         = grant ? i_req1_a1   : i_req0_a1;
      r_d.a2         = grant ? i_req1_a2   : i_req0_a2;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      r_q <= AluLogicArbiter_r_reset;
    end else begin
      r_q <= r_d;
    end
  end

  // Output decode; everything is forced low while reset is asserted.
  always_comb begin
    o_req0_ready  = i_nrst && accept && !grant;
    o_req1_ready  = i_nrst && accept && grant;
    o_resp0_valid = i_nrst && (r_q.state == RESP) && !r_q.owner;
    o_resp1_valid = i_nrst && (r_q.state == RESP) && r_q.owner;
    o_resp0_data  = o_resp0_valid ? i_alu_res : '0;
    o_resp1_data  = o_resp1_valid ? i_alu_res : '0;
    o_alu_op      = i_nrst ? r_q.op   : 3'b000;
    o_alu_rv32    = i_nrst && r_q.rv32;
    o_alu_a1      = i_nrst ? r_q.a1   : '0;
    o_alu_a2      = i_nrst ? r_q.a2   : '0;
  end

endmodule

// File: tb/tb_alu_logic_arbiter.sv
// Self-checking bench for alu_logic_arbiter: directed vector table, hand
// sequences for reset/contention/backpressure, and a randomized phase
// checked against a transaction-level model.
module tb_alu_logic_arbiter;

  logic        clk = 1'b0;
  logic        nrst;
  logic        req0_valid, req0_ready, req0_rv32;
  logic [2:0]  req0_op;
  logic [63:0] req0_a1, req0_a2;
  logic        resp0_valid, resp0_ready;
  logic [63:0] resp0_data;
  logic        req1_valid, req1_ready, req1_rv32;
  logic [2:0]  req1_op;
  logic [63:0] req1_a1, req1_a2;
  logic        resp1_valid, resp1_ready;
  logic [63:0] resp1_data;
  logic [2:0]  alu_op;
  logic        alu_rv32;
  logic [63:0] alu_a1, alu_a2;
  logic [63:0] alu_res = '0;

  int n_pass  = 0;
  int n_total = 0;

  // Transaction-level model state.
  bit          m_busy;
  int          m_owner;
  int          m_age;
  int          m_last;
  logic [63:0] m_exp;
  int          delivered [2];
  int          grants [2];
  logic [63:0] snap_d0;

  always #5 clk = ~clk;

  alu_logic_arbiter dut (
    .i_clk(clk), .i_nrst(nrst),
    .i_req0_valid(req0_valid), .o_req0_ready(req0_ready), .i_req0_op(req0_op),
    .i_req0_rv32(req0_rv32), .i_req0_a1(req0_a1), .i_req0_a2(req0_a2),
    .o_resp0_valid(resp0_valid), .i_resp0_ready(resp0_ready), .o_resp0_data(resp0_data),
    .i_req1_valid(req1_valid), .o_req1_ready(req1_ready), .i_req1_op(req1_op),
    .i_req1_rv32(req1_rv32), .i_req1_a1(req1_a1), .i_req1_a2(req1_a2),
    .o_resp1_valid(resp1_valid), .i_resp1_ready(resp1_ready), .o_resp1_data(resp1_data),
    .o_alu_op(alu_op), .o_alu_rv32(alu_rv32), .o_alu_a1(alu_a1), .o_alu_a2(alu_a2),
    .i_alu_res(alu_res)
  );

  // Behaviour of the shared logic unit: AND/OR/XOR selected one-hot,
  // optional sign-extension from bit 31.
  function automatic logic [63:0] unit_fn(logic [2:0] op, logic rv32, logic [63:0] a1,
                                          logic [63:0] a2);
    logic [63:0] r;
    r = '0;
    if (op[0]) r = r | (a1 & a2);
    if (op[1]) r = r | (a1 | a2);
    if (op[2]) r = r | (a1 ^ a2);
    if (rv32) r = {{32{r[31]}}, r[31:0]};
    return r;
  endfunction

  // Registered shared unit: result reflects its inputs one cycle earlier.
  always @(posedge clk) alu_res <= unit_fn(alu_op, alu_rv32, alu_a1, alu_a2);

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  task automatic drive_req(int who, logic v, logic [2:0] op, logic rv32, logic [63:0] a1,
                           logic [63:0] a2);
    if (who == 0) begin
      req0_valid = v; req0_op = op; req0_rv32 = rv32; req0_a1 = a1; req0_a2 = a2;
    end else begin
      req1_valid = v; req1_op = op; req1_rv32 = rv32; req1_a1 = a1; req1_a2 = a2;
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_age = 0; m_last = 1;
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    req0_valid = 0; req1_valid = 0;
    resp0_ready = 1; resp1_ready = 1;
    @(posedge clk); #1;
    nrst = 1'b1;
    model_reset();
  endtask

  // One clock of model-checked operation: compare at negedge, update model at posedge.
  task automatic cycle(string tag);
    bit          free, e_r0, e_r1, e_v0, e_v1, hs;
    int          g;
    logic [63:0] new_exp;
    @(negedge clk);
    snap_d0 = resp0_data;
    e_v0 = m_busy && (m_age >= 2) && (m_owner == 0);
    e_v1 = m_busy && (m_age >= 2) && (m_owner == 1);
    hs   = (e_v0 && resp0_ready) || (e_v1 && resp1_ready);
    free = !m_busy || hs;
    g = -1;
    if (free && (req0_valid || req1_valid)) begin
      if (req0_valid && req1_valid) g = 1 - m_last;
      else g = req0_valid ? 0 : 1;
    end
    e_r0 = (g == 0);
    e_r1 = (g == 1);
    chk({tag, "_ready0"}, req0_ready, e_r0);
    chk({tag, "_ready1"}, req1_ready, e_r1);
    chk({tag, "_rvalid0"}, resp0_valid, e_v0);
    chk({tag, "_rvalid1"}, resp1_valid, e_v1);
    if (e_v0) chk({tag, "_rdata0"}, resp0_data, m_exp);
    if (e_v1) chk({tag, "_rdata1"}, resp1_data, m_exp);
    new_exp = '0;
    if (g == 0) new_exp = unit_fn(req0_op, req0_rv32, req0_a1, req0_a2);
    if (g == 1) new_exp = unit_fn(req1_op, req1_rv32, req1_a1, req1_a2);
    @(posedge clk);
    if (m_busy) m_age++;
    if (hs) begin
      delivered[m_owner]++;
      m_busy = 0;
    end
    if (g >= 0) begin
      m_busy = 1; m_owner = g; m_age = 1; m_last = g; m_exp = new_exp;
      grants[g]++;
    end
    #1;
  endtask

  typedef struct {
    int          who;
    logic [2:0]  op;
    logic        rv32;
    logic [63:0] a1;
    logic [63:0] a2;
    logic [63:0] exp;
    string       name;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{0, 3'b001, 1'b0, 64'hF0F0F0F0F0F0F0F0, 64'hFF00FF00FF00FF00,
                64'hF000F000F000F000, "and64"};
    vecs[1] = '{1, 3'b010, 1'b1, 64'h0000000080000000, 64'h0000000000000001,
                64'hFFFFFFFF80000001, "or_rv32"};
    vecs[2] = '{0, 3'b100, 1'b0, 64'hFFFF0000FFFF0000, 64'h0F0F0F0F0F0F0F0F,
                64'hF0F00F0FF0F00F0F, "xor64"};
    vecs[3] = '{1, 3'b001, 1'b1, 64'hFFFFFFFF7FFFFFFF, 64'hFFFFFFFFFFFFFFFF,
                64'h000000007FFFFFFF, "and_rv32_pos"};
    vecs[4] = '{0, 3'b100, 1'b1, 64'h0000000000000000, 64'h0000000080000000,
                64'hFFFFFFFF80000000, "xor_rv32_neg"};
    vecs[5] = '{1, 3'b010, 1'b0, 64'h1234567800000000, 64'h0000000087654321,
                64'h1234567887654321, "or64"};

    nrst = 1'b0;
    drive_req(0, 0, 3'b000, 0, '0, '0);
    drive_req(1, 0, 3'b000, 0, '0, '0);
    resp0_ready = 1; resp1_ready = 1;
    delivered[0] = 0; delivered[1] = 0; grants[0] = 0; grants[1] = 0;
    model_reset();
    m_exp = '0;
    snap_d0 = '0;

    // Reset with both requesters valid: all outputs low, then req0 wins first.
    drive_req(0, 1, 3'b001, 0, 64'h1, 64'h1);
    drive_req(1, 1, 3'b010, 0, 64'h2, 64'h2);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    chk("rst_rvalid0", resp0_valid, 0);
    chk("rst_rvalid1", resp1_valid, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_alu_a1", alu_a1, 0);
    chk("rst_alu_a2", alu_a2, 0);
    @(posedge clk); #1;
    nrst = 1'b1;
    @(negedge clk);
    chk("rel_ready0", req0_ready, 1);
    chk("rel_ready1", req1_ready, 0);
    chk("rel_alu_op_idle", alu_op, 0);
    req0_valid = 0; req1_valid = 0;
    @(posedge clk); #1;

    // Directed single operations from the vector table.
    for (int i = 0; i < 6; i++) begin
      do_reset();
      drive_req(vecs[i].who, 1, vecs[i].op, vecs[i].rv32, vecs[i].a1, vecs[i].a2);
      @(negedge clk);
      chk({vecs[i].name, "_acc_ready"}, vecs[i].who == 0 ? req0_ready : req1_ready, 1);
      chk({vecs[i].name, "_acc_other"}, vecs[i].who == 0 ? req1_ready : req0_ready, 0);
      @(posedge clk); #1;
      drive_req(vecs[i].who, 0, 3'b000, 0, '1, '1);
      @(negedge clk);
      chk({vecs[i].name, "_exec_v"}, resp0_valid | resp1_valid, 0);
      chk({vecs[i].name, "_exec_op"}, alu_op, vecs[i].op);
      @(posedge clk); #1;
      @(negedge clk);
      chk({vecs[i].name, "_resp_v"}, vecs[i].who == 0 ? resp0_valid : resp1_valid, 1);
      chk({vecs[i].name, "_resp_d"}, vecs[i].who == 0 ? resp0_data : resp1_data, vecs[i].exp);
      chk({vecs[i].name, "_other_v"}, vecs[i].who == 0 ? resp1_valid : resp0_valid, 0);
      chk({vecs[i].name, "_other_d"}, vecs[i].who == 0 ? resp1_data : resp0_data, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk({vecs[i].name, "_after_v"}, resp0_valid | resp1_valid, 0);
      @(posedge clk); #1;
    end

    // Contention: both continuously valid, results always consumed.
    do_reset();
    delivered[0] = 0; delivered[1] = 0; grants[0] = 0; grants[1] = 0;
    drive_req(0, 1, 3'b001, 0, 64'hAAAA5555AAAA5555, 64'h0FF00FF00FF00FF0);
    drive_req(1, 1, 3'b100, 1, 64'h00000000FFFF0000, 64'h000000000F0F0F0F);
    for (int c = 0; c < 17; c++) cycle("cont");
    chk("cont_deliv0", delivered[0], 4);
    chk("cont_deliv1", delivered[1], 4);
    req0_valid = 0; req1_valid = 0;

    // Backpressure on requester 0 while requester 1 waits.
    do_reset();
    drive_req(0, 1, 3'b010, 0, 64'h0123456789ABCDEF, 64'h1000000000000000);
    cycle("bp_acc");
    req0_valid = 0;
    resp0_ready = 0;
    drive_req(1, 1, 3'b001, 0, 64'hFFFFFFFFFFFFFFFF, 64'h00FF00FF00FF00FF);
    cycle("bp_exec");
    for (int c = 0; c < 5; c++) begin
      cycle("bp_hold");
      chk("bp_stable", snap_d0, 64'h1123456789ABCDEF);
    end
    req0_valid = 1;
    resp0_ready = 1;
    @(negedge clk);
    chk("bp_rel_ready1", req1_ready, 1);
    chk("bp_rel_ready0", req0_ready, 0);
    @(posedge clk); #1;
    m_busy = 1; m_owner = 1; m_age = 1; m_last = 1;
    m_exp = 64'h00FF00FF00FF00FF;
    req0_valid = 0; req1_valid = 0;
    cycle("bp_exec1");
    cycle("bp_resp1");

    // Reset while in EXEC: the pending result must never appear.
    do_reset();
    drive_req(0, 1, 3'b001, 0, 64'hFFFF, 64'hFFFF);
    cycle("r6_acc");
    req0_valid = 0;
    nrst = 0;
    @(negedge clk);
    chk("r6e_in_v0", resp0_valid, 0);
    chk("r6e_in_aluop", alu_op, 0);
    @(posedge clk); #1;
    nrst = 1;
    model_reset();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("r6e_post_v0", resp0_valid, 0);
      chk("r6e_post_d0", resp0_data, 0);
      @(posedge clk); #1;
    end

    // Reset while in RESP with the result not yet consumed.
    resp1_ready = 0;
    drive_req(1, 1, 3'b010, 0, 64'h5, 64'hA);
    cycle("r6r_acc");
    req1_valid = 0;
    cycle("r6r_exec");
    @(negedge clk);
    chk("r6r_resp_v1", resp1_valid, 1);
    chk("r6r_resp_d1", resp1_data, 64'hF);
    @(posedge clk); #1;
    nrst = 0;
    @(negedge clk);
    chk("r6r_in_v1", resp1_valid, 0);
    @(posedge clk); #1;
    nrst = 1;
    model_reset();
    resp1_ready = 1;
    @(negedge clk);
    chk("r6r_post_v1", resp1_valid, 0);
    chk("r6r_post_a1", alu_a1, 0);
    @(posedge clk); #1;

    // Randomized traffic against the model; operands change every cycle.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      logic [2:0] op0, op1;
      op0 = 3'b001 << $urandom_range(0, 2);
      op1 = 3'b001 << $urandom_range(0, 2);
      drive_req(0, $urandom_range(0, 9) < 6, op0, 1'($urandom_range(0, 1)),
                {$urandom, $urandom}, {$urandom, $urandom});
      drive_req(1, $urandom_range(0, 9) < 6, op1, 1'($urandom_range(0, 1)),
                {$urandom, $urandom}, {$urandom, $urandom});
      resp0_ready = $urandom_range(0, 9) < 7;
      resp1_ready = $urandom_range(0, 9) < 7;
      cycle("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
